// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: funct3 encodings, FSM states
// and the store byte-lane mask helper.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    // size is log2(bytes); result is sized for the widest (8-lane) bank
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit and dmem_ctrl.
interface dmem_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    localparam int AW = DM_ADDRESS + $clog2(DATA_W / 8);

    logic              req_valid;
    logic              req_ready;
    logic              MemWrite;
    logic [2:0]        funct3;
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] wd;
    logic              rsp_valid;
    logic [DATA_W-1:0] rd;
    logic              err;

    modport master (
        output req_valid, MemWrite, funct3, a, wd,
        input  req_ready, rsp_valid, rd, err
    );

    modport slave (
        input  req_valid, MemWrite, funct3, a, wd,
        output req_ready, rsp_valid, rd, err
    );

endinterface

// File: rtl/dmem_bank.sv
// Byte-enabled synchronous single-port RAM, NB lanes of 8 bits, read-before-write.
module dmem_bank #(
    parameter int AW = 9,
    parameter int NB = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [NB-1:0]   be,
    input  logic [AW-1:0]   addr,
    input  logic [NB*8-1:0] wdata,
    output logic [NB*8-1:0] rdata
);
`ifdef __SIM__
    logic [NB-1:0][7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr][i] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end
`else
    // One byte-wide array per lane so each maps onto a macro lane write enable
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] lane [2**AW];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (we && be[i]) lane[addr] <= wdata[i*8 +: 8];
            q <= lane[addr];
        end

        assign rdata[i*8 +: 8] = q;
    end
`endif
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load (3 cycles) or store (2 cycles) at a time,
// byte/half/word/double access with alignment and funct3 checking.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    state_t            state, state_n;
    logic              accept, illegal, misalign, bad, bad_q, sbit;
    logic [1:0]        size;
    logic [2:0]        off, off_q, f3_q;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata, rdata, sh, keep, ext;

    assign accept   = bus.req_valid && bus.req_ready;
    assign size     = bus.funct3[1:0];
    assign off      = 3'(bus.a[OB-1:0]);
    assign illegal  = (bus.funct3 == 3'b111) ||
                      (DATA_W == 32 && (bus.funct3 == F3_D || bus.funct3 == F3_WU));
    assign misalign = (size == 2'd1 && off[0]) ||
                      (size == 2'd2 && off[1:0] != 2'd0) ||
                      (size == 2'd3 && off != 3'd0);
    assign bad      = illegal || misalign;
    assign be       = NB'(byte_mask(size, off));
    assign wdata    = bus.wd << {off, 3'b000};

    dmem_bank #(.AW(DM_ADDRESS), .NB(NB)) u_bank (
        .clk   (clk),
        .we    (accept && bus.MemWrite && !bad),
        .be    (be),
        .addr  (bus.a[DM_ADDRESS+OB-1:OB]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_n = bus.MemWrite ? RESP : RD_WAIT;
            end
            RD_WAIT: state_n = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Extract the addressed lanes; the top bit of keep marks the sign position
    always_comb begin
        sh = rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'd0:    keep = DATA_W'(8'hFF);
            2'd1:    keep = DATA_W'(16'hFFFF);
            2'd2:    keep = DATA_W'(32'hFFFF_FFFF);
            default: keep = '1;
        endcase
        sbit = |(sh & keep & ~(keep >> 1));
        ext  = (sh & keep) | ((!f3_q[2] && sbit) ? ~keep : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q    <= 3'd0;
            off_q   <= 3'd0;
            bad_q   <= 1'b0;
            bus.rd  <= '0;
            bus.err <= 1'b0;
        end else begin
            if (accept) begin
                f3_q  <= bus.funct3;
                off_q <= off;
                bad_q <= bad;
                if (bus.MemWrite) begin
                    bus.rd  <= '0;
                    bus.err <= bad;
                end
            end
            if (state == RD_WAIT) begin
                bus.rd  <= bad_q ? '0 : ext;
                bus.err <= bad_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed + random bench for dmem_ctrl at DATA_W=32 and DATA_W=64 against a
// byte-array reference model.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_if #(.DM_ADDRESS(9), .DATA_W(32)) b32 ();
    dmem_if #(.DM_ADDRESS(9), .DATA_W(64)) b64 ();

    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut32 (.clk(clk), .reset(rst), .bus(b32));
    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(64)) dut64 (.clk(clk), .reset(rst), .bus(b64));

    always #5 clk = ~clk;

    logic [7:0] m32 [2048];
    logic [7:0] m64 [4096];

    typedef struct {
        bit         st;
        logic [63:0] rd;
        bit         err;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 32) ? b32.req_ready : b64.req_ready;
    endfunction

    function automatic logic rsp_v(input int w);
        return (w == 32) ? b32.rsp_valid : b64.rsp_valid;
    endfunction

    function automatic logic [63:0] rd_of(input int w);
        return (w == 32) ? {32'd0, b32.rd} : b64.rd;
    endfunction

    function automatic logic err_of(input int w);
        return (w == 32) ? b32.err : b64.err;
    endfunction

    task automatic drive(input int w, input bit v, input bit st, input logic [2:0] f3,
                         input int addr, input logic [63:0] data);
        if (w == 32) begin
            b32.req_valid = v; b32.MemWrite = st; b32.funct3 = f3;
            b32.a = 11'(addr); b32.wd = data[31:0];
        end else begin
            b64.req_valid = v; b64.MemWrite = st; b64.funct3 = f3;
            b64.a = 12'(addr); b64.wd = data;
        end
    endtask

    // Reference: little-endian byte memory, naturally aligned accesses
    task automatic model(input int w, input bit st, input logic [2:0] f3, input int addr,
                         input logic [63:0] data, output logic [63:0] erd, output bit eerr);
        int sz;
        logic [63:0] v;
        sz   = 1 << f3[1:0];
        eerr = (f3 == 3'b111) || (w == 32 && (f3 == 3'b011 || f3 == 3'b110)) || (addr % sz != 0);
        erd  = '0;
        if (!eerr) begin
            if (st) begin
                for (int i = 0; i < sz; i++) begin
                    if (w == 32) m32[addr+i] = data[8*i +: 8];
                    else         m64[addr+i] = data[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = (w == 32) ? m32[addr+i] : m64[addr+i];
                if (!f3[2] && sz * 8 < w && v[8*sz-1])
                    for (int i = sz * 8; i < w; i++) v[i] = 1'b1;
                erd = v;
            end
        end
    endtask

    task automatic access(input int w, input bit st, input logic [2:0] f3, input int addr,
                          input logic [63:0] data, output logic [63:0] rdv, output bit errv,
                          output int lat);
        int n = 0;
        @(negedge clk);
        drive(w, 1'b1, st, f3, addr, data);
        while (!rdy(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(n < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        drive(w, 1'b0, 1'b0, 3'b000, 0, 64'd0);
        while (!rsp_v(w) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdv  = rd_of(w);
        errv = err_of(w);
    endtask

    task automatic op(input int w, input bit st, input logic [2:0] f3, input int addr,
                      input logic [63:0] data, output logic [63:0] rdv, output bit errv);
        logic [63:0] erd;
        bit eerr;
        int lat;
        string ctx;
        ctx = $sformatf("w%0d %s f3=%0d a=%h", w, st ? "st" : "ld", f3, addr);
        model(w, st, f3, addr, data, erd, eerr);
        access(w, st, f3, addr, data, rdv, errv, lat);
        chk({ctx, " latency"}, 64'(lat), st ? 64'd1 : 64'd2);
        chk({ctx, " err"}, 64'(errv), 64'(eerr));
        if (!st || eerr) chk({ctx, " rd"}, rdv, erd);
        @(negedge clk);
        chk({ctx, " rsp_pulse"}, 64'(rsp_v(w)), 64'd0);
    endtask

    logic [2:0]  f3tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010};
    bit          bst   [12];
    logic [2:0]  bf3   [12];
    int          baddr [12];
    logic [63:0] bdata [12];

    initial begin
        logic [63:0] r;
        bit e, saw;
        exp_t expq[$];
        exp_t x;
        int idx, outst, nrsp, cyc, addr;
        logic [2:0] f3;

        rst = 1'b1;
        drive(32, 1'b0, 1'b0, 3'b000, 0, 64'd0);
        drive(64, 1'b0, 1'b0, 3'b000, 0, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst32 req_ready", 64'(b32.req_ready), 64'd1);
        chk("rst32 rsp_valid", 64'(b32.rsp_valid), 64'd0);
        chk("rst32 err", 64'(b32.err), 64'd0);
        chk("rst32 rd", 64'(b32.rd), 64'd0);
        chk("rst64 req_ready", 64'(b64.req_ready), 64'd1);
        chk("rst64 rsp_valid", 64'(b64.rsp_valid), 64'd0);
        chk("rst64 rd", b64.rd, 64'd0);
        rst = 1'b0;

        // Memory is not reset: give both banks and the model a known zero state
        for (int i = 0; i < 512; i++) op(32, 1'b1, 3'b010, i * 4, 64'd0, r, e);
        for (int i = 0; i < 512; i++) op(64, 1'b1, 3'b011, i * 8, 64'd0, r, e);

        op(32, 1'b1, 3'b010, 'h010, 64'hDEADBEEF, r, e);
        op(32, 1'b0, 3'b010, 'h010, 64'd0, r, e);
        chk("lw_deadbeef", r, 64'hDEADBEEF);
        op(32, 1'b1, 3'b000, 'h013, 64'h80, r, e);
        op(32, 1'b0, 3'b000, 'h013, 64'd0, r, e);
        chk("lb_sext", r, 64'hFFFFFF80);
        op(32, 1'b0, 3'b100, 'h013, 64'd0, r, e);
        chk("lbu_zext", r, 64'h00000080);
        op(32, 1'b0, 3'b010, 'h010, 64'd0, r, e);
        chk("lw_merged", r, 64'h80ADBEEF);
        op(32, 1'b1, 3'b001, 'h011, 64'h1234, r, e);
        chk("sh_misaligned_err", 64'(e), 64'd1);
        op(32, 1'b0, 3'b010, 'h010, 64'd0, r, e);
        chk("lw_unchanged", r, 64'h80ADBEEF);
        op(32, 1'b0, 3'b011, 'h018, 64'd0, r, e);
        chk("ld_illegal32_err", 64'(e), 64'd1);
        op(32, 1'b1, 3'b010, 'h000, 64'h11111111, r, e);
        op(32, 1'b1, 3'b010, 'h7FC, 64'h22222222, r, e);
        op(32, 1'b0, 3'b010, 'h000, 64'd0, r, e);
        chk("lw_bottom", r, 64'h11111111);
        op(32, 1'b0, 3'b010, 'h7FC, 64'd0, r, e);
        chk("lw_top", r, 64'h22222222);

        op(64, 1'b1, 3'b011, 'h8, 64'h0123456789ABCDEF, r, e);
        op(64, 1'b0, 3'b010, 'hC, 64'd0, r, e);
        chk("lw64_hi", r, 64'h0000000001234567);
        op(64, 1'b0, 3'b110, 'h8, 64'd0, r, e);
        chk("lwu64", r, 64'h0000000089ABCDEF);
        op(64, 1'b0, 3'b010, 'h8, 64'd0, r, e);
        chk("lw64_sext", r, 64'hFFFFFFFF89ABCDEF);
        op(64, 1'b1, 3'b011, 'hFF8, 64'hA5A5A5A5_5A5A5A5A, r, e);
        op(64, 1'b0, 3'b011, 'hFF8, 64'd0, r, e);
        chk("ld64_top", r, 64'hA5A5A5A5_5A5A5A5A);
        op(64, 1'b0, 3'b111, 'h10, 64'd0, r, e);
        chk("f3_111_err", 64'(e), 64'd1);

        // Reset during RD_WAIT aborts the load; content written earlier survives
        op(32, 1'b1, 3'b010, 'h020, 64'hCAFEF00D, r, e);
        op(32, 1'b0, 3'b010, 'h020, 64'd0, r, e);
        @(negedge clk);
        drive(32, 1'b1, 1'b0, 3'b010, 'h020, 64'd0);
        @(posedge clk);
        @(negedge clk);
        drive(32, 1'b0, 1'b0, 3'b000, 0, 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst req_ready", 64'(b32.req_ready), 64'd1);
        chk("midrst rsp_valid", 64'(b32.rsp_valid), 64'd0);
        chk("midrst err", 64'(b32.err), 64'd0);
        chk("midrst rd", 64'(b32.rd), 64'd0);
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (b32.rsp_valid) saw = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (b32.rsp_valid) saw = 1'b1;
        end
        chk("midrst no_rsp", 64'(saw), 64'd0);
        op(32, 1'b0, 3'b010, 'h020, 64'd0, r, e);
        chk("midrst content", r, 64'hCAFEF00D);

        // Back-to-back with req_valid held high; small address window forces store->load reuse
        for (int i = 0; i < 12; i++) begin
            bst[i]   = ($urandom_range(0, 1) == 1);
            bf3[i]   = f3tab[$urandom_range(0, 5)];
            baddr[i] = 'h40 + $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) baddr[i] = baddr[i] & ~((1 << bf3[i][1:0]) - 1);
            bdata[i] = {$urandom, $urandom};
        end
        idx = 0; outst = 0; nrsp = 0; cyc = 0;
        @(negedge clk);
        while ((idx < 12 || outst > 0) && cyc < 200) begin
            if (outst > 0) chk("b2b ready_low", 64'(b32.req_ready), 64'd0);
            if (b32.rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("b2b extra_rsp", 64'd1, 64'd0);
                end else begin
                    x = expq.pop_front();
                    chk($sformatf("b2b[%0d] err", nrsp), 64'(b32.err), 64'(x.err));
                    if (!x.st || x.err) chk($sformatf("b2b[%0d] rd", nrsp), 64'(b32.rd), x.rd);
                    outst--;
                    nrsp++;
                end
            end
            if (idx < 12) begin
                drive(32, 1'b1, bst[idx], bf3[idx], baddr[idx], bdata[idx]);
                if (b32.req_ready) begin
                    x.st = bst[idx];
                    model(32, bst[idx], bf3[idx], baddr[idx], bdata[idx], x.rd, x.err);
                    expq.push_back(x);
                    outst++;
                    idx++;
                end
            end else begin
                drive(32, 1'b0, 1'b0, 3'b000, 0, 64'd0);
            end
            @(negedge clk);
            cyc++;
        end
        drive(32, 1'b0, 1'b0, 3'b000, 0, 64'd0);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (b32.rsp_valid) saw = 1'b1;
        end
        chk("b2b responses", 64'(nrsp), 64'd12);
        chk("b2b no_trailing_rsp", 64'(saw), 64'd0);

        for (int i = 0; i < 150; i++) begin
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 2047);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << f3[1:0]) - 1);
            op(32, ($urandom_range(0, 1) == 1), f3, addr, {$urandom, $urandom}, r, e);
        end
        for (int i = 0; i < 150; i++) begin
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << f3[1:0]) - 1);
            op(64, ($urandom_range(0, 1) == 1), f3, addr, {$urandom, $urandom}, r, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
